rs_issue_sched: RTL and testbench
=================================

Name: rs_issue_sched

Overview:
- Issue scheduler for the five-slot reservation station: one slot per FU class (0=ALU, 1=LD, 2=ST, 3=FP1, 4=FP2).
- Accepts allocations from dispatch, snoops the CDB to wake pending operands, and round-robin selects one fully ready slot per cycle.
- The selected slot drives a registered valid/ready issue port toward the execute stage. The block sits between rename/dispatch and the FU issue mux.

Parameters:
- NUM_SLOTS, 5, number of RS slots (one per FU class)
- TAG_W, 5, ROB tag width
- XLEN, 32, operand width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- squash  in  1  pipeline flush; clears all state
- alloc_valid  in  1  dispatch presents an instruction
- alloc_slot  in  3  target slot index (0..NUM_SLOTS-1)
- alloc_op  in  FU_FUNC  operation code
- alloc_tag  in  TAG_W  ROB destination tag
- alloc_s1_tag, alloc_s2_tag  in  TAG_W  source producer tags
- alloc_v1, alloc_v2  in  XLEN  source values (valid when the matching ready bit is 1)
- alloc_r1, alloc_r2  in  1  source ready flags
- alloc_accept  out  1  combinational: alloc_valid && !slot_busy[alloc_slot] && !squash && alloc_slot<NUM_SLOTS
- slot_busy  out  NUM_SLOTS  registered per-slot occupancy
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  XLEN  broadcast value
- issue_valid  out  1  issue register holds an instruction
- issue_ready  in  1  execute stage accepts
- issue_slot  out  3  originating slot / FU class
- issue_op  out  FU_FUNC  operation
- issue_tag  out  TAG_W  destination tag
- issue_v1, issue_v2  out  XLEN  operands

Behaviour:
- Reset/squash: all slot_busy=0, ready bits=0, issue_valid=0, rr_ptr=0. Data outputs reset to 0.
- Squash is synchronous and has priority over alloc, wakeup and issue in the same cycle.
- Allocation: on alloc_accept, the slot is written at the clock edge and busy=1.
- Allocation bypass: if cdb_valid, !alloc_rX and cdb_tag==alloc_sX_tag, the slot stores cdb_value with ready=1.
- Allocation into a busy slot or an out-of-range index is dropped (alloc_accept=0).
- Wakeup: every busy slot with a not-ready source whose tag equals cdb_tag under cdb_valid captures cdb_value and sets ready. Both sources may wake in the same cycle.
- Eligibility: busy && r1 && r2, evaluated on registered state. A slot is eligible at the earliest one cycle after allocation or wakeup; there is no same-cycle bypass to select.
- Issue register FSM has two states:
  - EMPTY: if any slot is eligible, load the winner and go to HOLD; else stay in EMPTY.
  - HOLD: issue_valid=1. On issue_ready, either load the next winner (stay in HOLD) or go to EMPTY if none is eligible. Without issue_ready, hold every output stable.
- A load occurs when the state is EMPTY or the HOLD handshake completes. On load, the winning slot's busy is cleared in the same edge, so the slot can be reallocated the next cycle.
- Sustained throughput is 1 issue per cycle.
- Arbitration: round-robin starting at rr_ptr and searching upward with wrap at NUM_SLOTS-1 -> 0. After a load, rr_ptr = winner+1 (mod NUM_SLOTS). rr_ptr does not change when nothing loads.
- Simultaneous alloc and load on the same slot is impossible: alloc_accept requires registered busy=0, while load requires busy=1.
- Allocation into a slot being freed the same cycle is rejected. Dispatch retries the next cycle.
- A CDB tag matching no pending source is ignored. Tag value 0 carries no special meaning.

Decomposition:
- Shared package (sys_defs): RS_ENTRY typedef (busy, op_code, rob_target_index, source indices, values, ready bits), FU_FUNC, an FU class enum mapping to slot indices, RS_NUM_ENTRY.
- Sub-module rr_arbiter (NUM_SLOTS request vector plus pointer -> one-hot grant and index). It is purely combinational and is unit-tested separately.

Test Plan:
- Basic issue: alloc slot 0 with op ADD, tag 3, r1=r2=1, v1=5, v2=7, issue_ready=1. Expect issue_valid one cycle later with tag 3, v1=5, v2=7, and slot_busy[0]=0 at the same edge.
- CDB wakeup: alloc slot 1 with s1_tag=9, r1=0, r2=1. Then cdb_valid, tag 9, value 0xDEAD. Expect issue of slot 1 with v1=0xDEAD two cycles after the CDB cycle, and no issue before the wakeup.
- Allocation bypass: alloc slot 2 with s2_tag=4, r2=0, while cdb_valid, tag 4, value 0x11 in the same cycle. Expect slot 2 issued next cycle with v2=0x11.
- Round-robin and backpressure: slots 0, 3 and 4 all ready, issue_ready=0 for 3 cycles, then 1. Expect slot 0 held stable for 3 cycles, then issue order 3, 4.
- Busy reject: alloc slot 1 while it is busy. Expect alloc_accept=0 and the entry unchanged. Alloc the same slot the cycle after it issues: accepted.
- Squash/reset mid-operation: with issue HOLD active and 3 slots busy, assert squash. Expect issue_valid=0 and slot_busy=0 next cycle. Assert async reset mid-cycle: outputs clear immediately.

Source files
------------

// File: rtl/rs_issue_sched_pkg.sv
// Shared types for the reservation-station issue scheduler.
// Holds the operation encoding, the FU class to slot mapping, the RS entry
// payload and the default sizing constants used by the scheduler and bench.
package rs_issue_sched_pkg;

  localparam int unsigned RS_NUM_ENTRY = 5;
  localparam int unsigned RS_TAG_W     = 5;
  localparam int unsigned RS_XLEN      = 32;
  localparam int unsigned RS_SLOT_W    = 3;

  // Operation code carried from dispatch to execute.
  typedef enum logic [3:0] {
    FU_ADD  = 4'd0,
    FU_SUB  = 4'd1,
    FU_AND  = 4'd2,
    FU_OR   = 4'd3,
    FU_XOR  = 4'd4,
    FU_SLL  = 4'd5,
    FU_SRL  = 4'd6,
    FU_LD   = 4'd7,
    FU_ST   = 4'd8,
    FU_FADD = 4'd9,
    FU_FMUL = 4'd10,
    FU_FDIV = 4'd11
  } FU_FUNC;

  // FU class; the encoding is the RS slot index owned by that class.
  typedef enum logic [RS_SLOT_W-1:0] {
    FC_ALU = 3'd0,
    FC_LD  = 3'd1,
    FC_ST  = 3'd2,
    FC_FP1 = 3'd3,
    FC_FP2 = 3'd4
  } FU_CLASS;

  // One reservation-station slot.
  typedef struct packed {
    logic                busy;
    FU_FUNC              op_code;
    logic [RS_TAG_W-1:0] rob_target_index;
    logic [RS_TAG_W-1:0] src1_index;
    logic [RS_TAG_W-1:0] src2_index;
    logic [RS_XLEN-1:0]  value1;
    logic [RS_XLEN-1:0]  value2;
    logic                r1;
    logic                r2;
  } RS_ENTRY;

endpackage

// File: rtl/rs_issue_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req         - per-slot request vector
//   ptr         - slot with highest priority this cycle; search runs upward and wraps
//   grant_c     - one-hot grant
//   grant_idx_c - index of the granted slot (0 when nothing is granted)
//   any_c       - at least one request was granted
module rs_issue_sched_rr_arbiter #(
  parameter int unsigned N     = 5,
  parameter int unsigned PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [PTR_W-1:0] grant_idx_c,
  output logic             any_c
);

  logic [PTR_W-1:0] idx;

  // First requester at or after ptr, modulo N.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    idx         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PTR_W'((32'(ptr) + i) % N);
      if (!any_c && req[idx]) begin
        any_c        = 1'b1;
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
      end
    end
  end

endmodule

// File: rtl/rs_issue_sched.sv
// Issue scheduler for the five-slot reservation station (one slot per FU class).
// Takes allocations from dispatch, wakes pending operands from the CDB and
// picks one fully ready slot per cycle round-robin into a registered
// valid/ready issue port.
// Ports:
//   clock, reset           - clock, asynchronous active-high reset
//   squash                 - synchronous flush of every slot and the issue register
//   alloc_*                - dispatch request; alloc_accept is combinational
//   slot_busy              - registered per-slot occupancy
//   cdb_valid/tag/value    - result broadcast used for wakeup and allocation bypass
//   issue_valid/ready      - handshake toward execute
//   issue_slot/op/tag/v1/v2 - registered issued instruction
module rs_issue_sched
  import rs_issue_sched_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = RS_NUM_ENTRY,
  parameter int unsigned TAG_W     = RS_TAG_W,
  parameter int unsigned XLEN      = RS_XLEN
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic                 alloc_valid,
  input  logic [RS_SLOT_W-1:0] alloc_slot,
  input  FU_FUNC               alloc_op,
  input  logic [TAG_W-1:0]     alloc_tag,
  input  logic [TAG_W-1:0]     alloc_s1_tag,
  input  logic [TAG_W-1:0]     alloc_s2_tag,
  input  logic [XLEN-1:0]      alloc_v1,
  input  logic [XLEN-1:0]      alloc_v2,
  input  logic                 alloc_r1,
  input  logic                 alloc_r2,
  output logic                 alloc_accept,
  output logic [NUM_SLOTS-1:0] slot_busy,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [XLEN-1:0]      cdb_value,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [RS_SLOT_W-1:0] issue_slot,
  output FU_FUNC               issue_op,
  output logic [TAG_W-1:0]     issue_tag,
  output logic [XLEN-1:0]      issue_v1,
  output logic [XLEN-1:0]      issue_v2
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  RS_ENTRY                rs_q [NUM_SLOTS];
  RS_ENTRY                rs_d [NUM_SLOTS];
  logic [RS_SLOT_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_SLOTS-1:0]   eligible_c;
  logic [NUM_SLOTS-1:0]   grant_c;
  logic [RS_SLOT_W-1:0]   grant_idx_c;
  logic                   any_c;
  logic                   load_c;
  logic                   sel_busy_c;
  logic                   sel_in_range_c;

  logic                   issue_valid_d;
  logic [RS_SLOT_W-1:0]   issue_slot_d;
  FU_FUNC                 issue_op_d;
  logic [TAG_W-1:0]       issue_tag_d;
  logic [XLEN-1:0]        issue_v1_d;
  logic [XLEN-1:0]        issue_v2_d;

  // Occupancy and eligibility come from registered state only.
  always_comb begin
    slot_busy  = '0;
    eligible_c = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_busy[i]  = rs_q[i].busy;
      eligible_c[i] = rs_q[i].busy && rs_q[i].r1 && rs_q[i].r2;
    end
  end

  // Busy lookup is done by compare so an out-of-range index never reads the array.
  always_comb begin
    sel_busy_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (alloc_slot == RS_SLOT_W'(i)) sel_busy_c = rs_q[i].busy;
    end
    sel_in_range_c = 32'(alloc_slot) < NUM_SLOTS;
    alloc_accept   = alloc_valid && !squash && sel_in_range_c && !sel_busy_c;
  end

  rs_issue_sched_rr_arbiter #(
    .N     (NUM_SLOTS),
    .PTR_W (RS_SLOT_W)
  ) u_arb (
    .req         (eligible_c),
    .ptr         (rr_ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .any_c       (any_c)
  );

  // Issue register next state and load decision.
  always_comb begin
    state_d       = state_q;
    load_c        = 1'b0;
    rr_ptr_d      = rr_ptr_q;
    issue_slot_d  = issue_slot;
    issue_op_d    = issue_op;
    issue_tag_d   = issue_tag;
    issue_v1_d    = issue_v1;
    issue_v2_d    = issue_v2;
    issue_valid_d = issue_valid;

    if (squash) begin
      state_d      = ST_EMPTY;
      rr_ptr_d     = '0;
      issue_slot_d = '0;
      issue_op_d   = FU_ADD;
      issue_tag_d  = '0;
      issue_v1_d   = '0;
      issue_v2_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (any_c) begin
            load_c  = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (issue_ready) begin
            if (any_c) load_c = 1'b1;
            else       state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase

      if (load_c) begin
        issue_slot_d = grant_idx_c;
        issue_op_d   = rs_q[grant_idx_c].op_code;
        issue_tag_d  = rs_q[grant_idx_c].rob_target_index;
        issue_v1_d   = rs_q[grant_idx_c].value1;
        issue_v2_d   = rs_q[grant_idx_c].value2;
        rr_ptr_d     = (32'(grant_idx_c) == NUM_SLOTS - 1) ? '0
                                                           : grant_idx_c + RS_SLOT_W'(1);
      end
    end

    issue_valid_d = (state_d == ST_HOLD);
  end

  // Slot updates: issue frees, dispatch writes (with CDB bypass), CDB wakes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      rs_d[i] = rs_q[i];
      if (rs_q[i].busy && cdb_valid) begin
        if (!rs_q[i].r1 && rs_q[i].src1_index == cdb_tag) begin
          rs_d[i].value1 = cdb_value;
          rs_d[i].r1     = 1'b1;
        end
        if (!rs_q[i].r2 && rs_q[i].src2_index == cdb_tag) begin
          rs_d[i].value2 = cdb_value;
          rs_d[i].r2     = 1'b1;
        end
      end
      if (load_c && grant_c[i]) begin
        rs_d[i] = '0;
      end else if (alloc_accept && alloc_slot == RS_SLOT_W'(i)) begin
        rs_d[i].busy             = 1'b1;
        rs_d[i].op_code          = alloc_op;
        rs_d[i].rob_target_index = alloc_tag;
        rs_d[i].src1_index       = alloc_s1_tag;
        rs_d[i].src2_index       = alloc_s2_tag;
        rs_d[i].r1    = alloc_r1 || (cdb_valid && cdb_tag == alloc_s1_tag);
        rs_d[i].r2    = alloc_r2 || (cdb_valid && cdb_tag == alloc_s2_tag);
        rs_d[i].value1 = (!alloc_r1 && cdb_valid && cdb_tag == alloc_s1_tag) ? cdb_value
                                                                            : alloc_v1;
        rs_d[i].value2 = (!alloc_r2 && cdb_valid && cdb_tag == alloc_s2_tag) ? cdb_value
                                                                            : alloc_v2;
      end
      if (squash) rs_d[i] = '0;
    end
  end

  // State, pointer, slots and issue register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      rr_ptr_q    <= '0;
      issue_valid <= 1'b0;
      issue_slot  <= '0;
      issue_op    <= FU_ADD;
      issue_tag   <= '0;
      issue_v1    <= '0;
      issue_v2    <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) rs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      issue_valid <= issue_valid_d;
      issue_slot  <= issue_slot_d;
      issue_op    <= issue_op_d;
      issue_tag   <= issue_tag_d;
      issue_v1    <= issue_v1_d;
      issue_v2    <= issue_v2_d;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) rs_q[i] <= rs_d[i];
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Scoreboard bench for rs_issue_sched: expected issues are queued as stimulus
// is driven and popped on every completed issue handshake.
module tb_rs_issue_sched;
  import rs_issue_sched_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        squash;
  logic        alloc_valid;
  logic [2:0]  alloc_slot;
  FU_FUNC      alloc_op;
  logic [4:0]  alloc_tag, alloc_s1_tag, alloc_s2_tag;
  logic [31:0] alloc_v1, alloc_v2;
  logic        alloc_r1, alloc_r2;
  logic        alloc_accept;
  logic [4:0]  slot_busy;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_slot;
  FU_FUNC      issue_op;
  logic [4:0]  issue_tag;
  logic [31:0] issue_v1, issue_v2;

  rs_issue_sched dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .alloc_valid  (alloc_valid),
    .alloc_slot   (alloc_slot),
    .alloc_op     (alloc_op),
    .alloc_tag    (alloc_tag),
    .alloc_s1_tag (alloc_s1_tag),
    .alloc_s2_tag (alloc_s2_tag),
    .alloc_v1     (alloc_v1),
    .alloc_v2     (alloc_v2),
    .alloc_r1     (alloc_r1),
    .alloc_r2     (alloc_r2),
    .alloc_accept (alloc_accept),
    .slot_busy    (slot_busy),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_slot   (issue_slot),
    .issue_op     (issue_op),
    .issue_tag    (issue_tag),
    .issue_v1     (issue_v1),
    .issue_v2     (issue_v2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  slot;
    FU_FUNC      op;
    logic [4:0]  tag;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_alloc();
    alloc_valid  = 1'b0;
    alloc_slot   = 3'd0;
    alloc_op     = FU_ADD;
    alloc_tag    = 5'd0;
    alloc_s1_tag = 5'd0;
    alloc_s2_tag = 5'd0;
    alloc_v1     = 32'd0;
    alloc_v2     = 32'd0;
    alloc_r1     = 1'b0;
    alloc_r2     = 1'b0;
  endtask

  task automatic set_alloc(input int slot, input FU_FUNC op, input int tag, input int s1,
                           input int s2, input logic [31:0] v1, input logic [31:0] v2,
                           input bit r1, input bit r2);
    alloc_valid  = 1'b1;
    alloc_slot   = 3'(slot);
    alloc_op     = op;
    alloc_tag    = 5'(tag);
    alloc_s1_tag = 5'(s1);
    alloc_s2_tag = 5'(s2);
    alloc_v1     = v1;
    alloc_v2     = v2;
    alloc_r1     = r1;
    alloc_r2     = r2;
    #1;
  endtask

  task automatic set_cdb(input bit v, input int tag, input logic [31:0] value);
    cdb_valid = v;
    cdb_tag   = 5'(tag);
    cdb_value = value;
  endtask

  task automatic push(input int slot, input FU_FUNC op, input int tag,
                      input logic [31:0] v1, input logic [31:0] v2);
    exp_t e;
    e.slot = 3'(slot);
    e.op   = op;
    e.tag  = 5'(tag);
    e.v1   = v1;
    e.v2   = v2;
    sb_q.push_back(e);
  endtask

  // Every completed handshake must match the oldest expected issue.
  always @(negedge clock) begin
    if (!reset && issue_valid && issue_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("issue_slot", 64'(issue_slot), 64'(mon_e.slot));
        check("issue_op",   64'(issue_op),   64'(mon_e.op));
        check("issue_tag",  64'(issue_tag),  64'(mon_e.tag));
        check("issue_v1",   64'(issue_v1),   64'(mon_e.v1));
        check("issue_v2",   64'(issue_v2),   64'(mon_e.v2));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_alloc();
    set_cdb(1'b0, 0, 32'd0);
    squash      = 1'b0;
    issue_ready = 1'b0;
    tick();
    tick();
    check("rst_busy",  64'(slot_busy),   64'd0);
    check("rst_valid", 64'(issue_valid), 64'd0);
    check("rst_tag",   64'(issue_tag),   64'd0);
    reset = 1'b0;
    #1;
    check("idle_accept", 64'(alloc_accept), 64'd0);

    // Basic issue.
    issue_ready = 1'b1;
    set_alloc(int'(FC_ALU), FU_ADD, 3, 0, 0, 32'd5, 32'd7, 1, 1);
    check("t1_accept", 64'(alloc_accept), 64'd1);
    push(0, FU_ADD, 3, 32'd5, 32'd7);
    tick();
    idle_alloc();
    check("t1_busy",    64'(slot_busy),   64'h01);
    check("t1_novalid", 64'(issue_valid), 64'd0);
    tick();
    check("t1_valid",    64'(issue_valid), 64'd1);
    check("t1_busy_clr", 64'(slot_busy),   64'd0);
    check("t1_tag",      64'(issue_tag),   64'd3);
    tick();
    check("t1_drain", 64'(issue_valid), 64'd0);

    // CDB wakeup, with an unrelated broadcast first.
    set_alloc(int'(FC_LD), FU_SUB, 7, 9, 0, 32'd0, 32'h22, 0, 1);
    check("t2_accept", 64'(alloc_accept), 64'd1);
    tick();
    idle_alloc();
    set_cdb(1'b1, 12, 32'hBEEF);
    tick();
    set_cdb(1'b0, 0, 32'd0);
    check("t2_wait0", 64'(issue_valid), 64'd0);
    check("t2_busy",  64'(slot_busy),   64'h02);
    tick();
    check("t2_wait1", 64'(issue_valid), 64'd0);
    set_cdb(1'b1, 9, 32'hDEAD);
    push(1, FU_SUB, 7, 32'hDEAD, 32'h22);
    tick();
    set_cdb(1'b0, 0, 32'd0);
    check("t2_not_yet", 64'(issue_valid), 64'd0);
    tick();
    check("t2_valid", 64'(issue_valid), 64'd1);
    check("t2_v1",    64'(issue_v1),    64'hDEAD);
    tick();
    check("t2_drain", 64'(issue_valid), 64'd0);

    // Allocation bypass from the CDB in the allocation cycle.
    set_cdb(1'b1, 4, 32'h11);
    set_alloc(int'(FC_ST), FU_LD, 10, 0, 4, 32'h100, 32'd0, 1, 0);
    check("t3_accept", 64'(alloc_accept), 64'd1);
    push(2, FU_LD, 10, 32'h100, 32'h11);
    tick();
    idle_alloc();
    set_cdb(1'b0, 0, 32'd0);
    check("t3_busy",    64'(slot_busy),   64'h04);
    check("t3_novalid", 64'(issue_valid), 64'd0);
    tick();
    check("t3_valid", 64'(issue_valid), 64'd1);
    check("t3_v2",    64'(issue_v2),    64'h11);
    tick();

    // Tag 0 wakes like any other tag.
    set_alloc(int'(FC_FP1), FU_FADD, 0, 0, 5, 32'd0, 32'h33, 0, 1);
    tick();
    idle_alloc();
    set_cdb(1'b1, 0, 32'hABC);
    push(3, FU_FADD, 0, 32'hABC, 32'h33);
    tick();
    set_cdb(1'b0, 0, 32'd0);
    tick();
    check("t3b_valid", 64'(issue_valid), 64'd1);
    check("t3b_v1",    64'(issue_v1),    64'hABC);
    tick();
    check("t3b_drain", 64'(issue_valid), 64'd0);

    // Round-robin under backpressure: slot 0 held, then 3, 4.
    issue_ready = 1'b0;
    squash      = 1'b1;
    tick();
    squash = 1'b0;
    set_alloc(0, FU_ADD, 1, 0, 0, 32'd1, 32'd2, 1, 1);
    push(0, FU_ADD, 1, 32'd1, 32'd2);
    tick();
    set_alloc(3, FU_FADD, 2, 0, 0, 32'd3, 32'd4, 1, 1);
    push(3, FU_FADD, 2, 32'd3, 32'd4);
    tick();
    check("t4_hold1_valid", 64'(issue_valid), 64'd1);
    check("t4_hold1_slot",  64'(issue_slot),  64'd0);
    set_alloc(4, FU_FMUL, 3, 0, 0, 32'd5, 32'd6, 1, 1);
    push(4, FU_FMUL, 3, 32'd5, 32'd6);
    tick();
    idle_alloc();
    check("t4_hold2_slot", 64'(issue_slot), 64'd0);
    check("t4_hold2_tag",  64'(issue_tag),  64'd1);
    check("t4_hold2_busy", 64'(slot_busy),  64'h18);
    tick();
    check("t4_hold3_slot", 64'(issue_slot), 64'd0);
    check("t4_hold3_v1",   64'(issue_v1),   64'd1);
    issue_ready = 1'b1;
    tick();
    check("t4_second", 64'(issue_slot), 64'd3);
    tick();
    check("t4_third", 64'(issue_slot), 64'd4);
    tick();
    check("t4_drain", 64'(issue_valid), 64'd0);

    // Pointer wrap: after slot 2 issues, slot 4 beats slot 1.
    issue_ready = 1'b0;
    set_alloc(2, FU_LD, 13, 0, 0, 32'h13, 32'h14, 1, 1);
    push(2, FU_LD, 13, 32'h13, 32'h14);
    tick();
    set_alloc(1, FU_ADD, 14, 0, 0, 32'h15, 32'h16, 1, 1);
    tick();
    set_alloc(4, FU_FMUL, 15, 0, 0, 32'h17, 32'h18, 1, 1);
    push(4, FU_FMUL, 15, 32'h17, 32'h18);
    push(1, FU_ADD, 14, 32'h15, 32'h16);
    tick();
    idle_alloc();
    check("t4b_first", 64'(issue_slot), 64'd2);
    issue_ready = 1'b1;
    tick();
    check("t4b_wrap", 64'(issue_slot), 64'd4);
    tick();
    check("t4b_last", 64'(issue_slot), 64'd1);
    tick();
    check("t4b_drain", 64'(issue_valid), 64'd0);

    // Busy reject, same-cycle free reject, then reallocation.
    issue_ready = 1'b0;
    set_alloc(1, FU_ADD, 5, 0, 0, 32'h55, 32'h66, 1, 1);
    push(1, FU_ADD, 5, 32'h55, 32'h66);
    tick();
    set_alloc(1, FU_SUB, 6, 0, 0, 32'h99, 32'h98, 1, 1);
    check("t5_busy_reject", 64'(alloc_accept), 64'd0);
    tick();
    check("t5_orig_tag", 64'(issue_tag), 64'd5);
    check("t5_orig_v1",  64'(issue_v1),  64'h55);
    check("t5_freed",    64'(slot_busy), 64'd0);
    set_alloc(1, FU_SUB, 6, 0, 0, 32'h99, 32'h98, 1, 1);
    check("t5_realloc", 64'(alloc_accept), 64'd1);
    push(1, FU_SUB, 6, 32'h99, 32'h98);
    tick();
    check("t5_busy", 64'(slot_busy), 64'h02);
    set_alloc(5, FU_ADD, 1, 0, 0, 32'd0, 32'd0, 1, 1);
    check("t5_oor5", 64'(alloc_accept), 64'd0);
    set_alloc(7, FU_ADD, 1, 0, 0, 32'd0, 32'd0, 1, 1);
    check("t5_oor7", 64'(alloc_accept), 64'd0);
    tick();
    idle_alloc();
    check("t5_oor_busy", 64'(slot_busy), 64'h02);
    issue_ready = 1'b1;
    tick();
    check("t5_next_tag", 64'(issue_tag), 64'd6);
    tick();
    check("t5_drain", 64'(issue_valid), 64'd0);

    // Squash with HOLD active and three slots waiting.
    issue_ready = 1'b0;
    set_alloc(3, FU_FADD, 8, 0, 0, 32'd8, 32'd8, 1, 1);
    tick();
    set_alloc(0, FU_ADD, 9, 30, 0, 32'd0, 32'd1, 0, 1);
    tick();
    set_alloc(2, FU_ST, 10, 30, 0, 32'd0, 32'd2, 0, 1);
    tick();
    set_alloc(4, FU_FMUL, 11, 30, 0, 32'd0, 32'd3, 0, 1);
    tick();
    idle_alloc();
    check("t6_pre_busy",  64'(slot_busy),   64'h15);
    check("t6_pre_valid", 64'(issue_valid), 64'd1);
    squash = 1'b1;
    set_alloc(1, FU_ADD, 12, 0, 0, 32'd1, 32'd1, 1, 1);
    check("t6_squash_accept", 64'(alloc_accept), 64'd0);
    tick();
    squash = 1'b0;
    idle_alloc();
    check("t6_valid", 64'(issue_valid), 64'd0);
    check("t6_busy",  64'(slot_busy),   64'd0);
    check("t6_tag",   64'(issue_tag),   64'd0);
    issue_ready = 1'b1;
    set_cdb(1'b1, 30, 32'h77);
    tick();
    set_cdb(1'b0, 0, 32'd0);
    tick();
    check("t6_no_ghost", 64'(issue_valid), 64'd0);

    // Asynchronous reset mid-cycle.
    issue_ready = 1'b0;
    set_alloc(3, FU_FADD, 11, 0, 0, 32'd1, 32'd2, 1, 1);
    tick();
    set_alloc(1, FU_ADD, 12, 31, 0, 32'd0, 32'd2, 0, 1);
    tick();
    idle_alloc();
    tick();
    check("t7_pre_valid", 64'(issue_valid), 64'd1);
    check("t7_pre_busy",  64'(slot_busy),   64'h02);
    #1 reset = 1'b1;
    #1;
    check("t7_valid", 64'(issue_valid), 64'd0);
    check("t7_busy",  64'(slot_busy),   64'd0);
    check("t7_tag",   64'(issue_tag),   64'd0);
    #1 reset = 1'b0;

    // Normal operation after reset.
    issue_ready = 1'b1;
    set_alloc(4, FU_FMUL, 12, 0, 0, 32'hA, 32'hB, 1, 1);
    push(4, FU_FMUL, 12, 32'hA, 32'hB);
    tick();
    idle_alloc();
    tick();
    check("t8_valid", 64'(issue_valid), 64'd1);
    check("t8_tag",   64'(issue_tag),   64'd12);
    tick();
    check("t8_drain", 64'(issue_valid), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
